axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares one AXI4 read channel (AR+R) between the I-cache and D-cache refill/uncached ports.
//  Grants one master per transaction and routes its AR, then its R beats, until RLAST.
//  One outstanding burst system-wide. Sits between the cache pair and the core AXI bridge.
// PARAMETERS
//  ARB_RR      1   1: round-robin between I/D; 0: fixed priority, D wins ties
//  ID_W        4   width of m_arid/m_rid; I-side ID=0, D-side ID=1
// PORTS
//  clk         in   1    clock
//  rst         in   1    reset, synchronous, active-high
//  i_araddr    in   32   I-side AR address (same for d_araddr)
//  i_arlen     in   8    I-side burst length-1 (same for d_arlen)
//  i_arsize    in   3    I-side beat size (same for d_arsize)
//  i_arvalid   in   1    I-side AR request (same for d_arvalid)
//  i_arready   out  1    I-side AR accept (same for d_arready)
//  i_rdata     out  32   R data, broadcast to both sides (same for d_rdata)
//  i_rlast     out  1    R last, gated by grant (same for d_rlast)
//  i_rvalid    out  1    R valid, gated by grant (same for d_rvalid)
//  i_rready    in   1    I-side R ready (same for d_rready)
//  m_araddr/m_arlen/m_arsize  out  32/8/3  AR payload to bridge
//  m_arid      out  ID_W grant index; m_arvalid out 1; m_arready in 1
//  m_rdata     in   32;  m_rid in ID_W; m_rlast in 1; m_rvalid in 1; m_rready out 1
// BEHAVIOUR
//  FSM (state reg + grant reg g, 0=I 1=D): IDLE -> ADDR -> DATA -> IDLE.
//  IDLE: no outputs asserted. If i_arvalid|d_arvalid: pick g (below), go ADDR next cycle.
//   One-cycle arbitration bubble: earliest m_arvalid is the cycle after a request appears.
//  Pick: only one valid -> that one. Both valid: ARB_RR=0 -> D; ARB_RR=1 -> the side NOT
//   granted last (last_g resets to D, so the first tie goes to I); last_g updates on every pick.
//  ADDR: m_ar* = selected side's ar* (comb mux on g); m_arid=g; m_arvalid=sel arvalid;
//   sel arready=m_arready, other arready=0. On m_arvalid&m_arready -> DATA.
//  DATA: m_rready=sel rready; sel rvalid/rlast=m_rvalid/m_rlast; other side rvalid=rlast=0.
//   rdata driven to both sides always. On m_rvalid&m_rready&m_rlast -> IDLE (next req may be
//   picked in that IDLE cycle). m_rid!=g in DATA: ignored for routing (single outstanding).
//  The block does not register AR payload: masters hold ar* stable while arvalid is high
//   (AXI rule; both caches comply). Non-granted master keeps arvalid high and waits.
//  arlen=0 (uncached single beat) is handled the same as a burst: first beat carries RLAST.
//  Reset (also mid-burst): state=IDLE, last_g=D; m_arvalid=m_rready=0, all *_arready=0,
//   *_rvalid=*_rlast=0 within the cycle reset is sampled. Bridge and caches reset together;
//   no draining of in-flight beats.
//  No combinational path from m_arready/m_rvalid back to m_arvalid/m_rready except via sel
//   side inputs (i.e. no loops are introduced).
// STRUCTURE
//  axi_pkg: typedef enum logic[1:0] {ARB_IDLE,ARB_ADDR,ARB_DATA} arb_state_t;
//   localparam GNT_I=1'b0, GNT_D=1'b1.
//  Sub-module rr_arb2: 2-req arbiter, inputs req[1:0], last_g, mode; output gnt index.
//  Top: FSM + grant register + AR/R muxes, ~150-200 lines.
// TESTING
//  I-only: i_arvalid, araddr=0x1FC00040, arlen=7; m_arready=1 -> m_arvalid at cycle+1, m_arid=0,
//   8 beats 0xA0..0xA7 reach i_rdata with i_rvalid; d_rvalid stays 0; IDLE after beat 8.
//  Tie RR: i,d arvalid same cycle x2 transactions -> grant order I,D (ARB_RR=1); ARB_RR=0 -> D,I.
//  Back-pressure: m_arready low 5 cycles then high -> m_ar* stable, i_arready high only on accept;
//   i_rready toggling -> m_rready follows, no beat lost or duplicated.
//  Uncached: d_arlen=0, m_rvalid+m_rlast on one beat 0xDEADBEEF -> d_rdata=0xDEADBEEF, IDLE next.
//  Pending D during I burst: d_arvalid rises mid-burst -> d_arready=0 until I RLAST, then D
//   granted with m_arvalid two cycles after RLAST.
//  Reset at beat 3 of 8 -> next cycle m_rready=0, all rvalid/arready 0, state IDLE; new I request
//   afterwards completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
// Imported by the two-requester arbiter and the top-level arbiter.
package axi_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_SIZE_W = 3;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic [AXI_SIZE_W-1:0] size;
    } ar_payload_t;

    function automatic logic other_side(input logic g);
        return ~g;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-requester grant selection: a lone requester always wins; a tie goes
// to the side not granted last (round-robin) or to D (fixed priority).
module rr_arb2
    import axi_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_g,
    input  logic       mode,
    output logic       gnt
);

    // Grant index from the request pair, tie resolved by mode.
    always_comb begin
        gnt = GNT_D;
        case (req)
            2'b01: gnt = GNT_I;
            2'b10: gnt = GNT_D;
            2'b11: begin
                if (mode) begin
                    gnt = other_side(last_g);
                end else begin
                    gnt = GNT_D;
                end
            end
            // No request: value is never used, hold history to keep it quiet.
            default: gnt = last_g;
        endcase
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel (AR+R) between the I-cache and D-cache ports,
// one burst in flight system-wide: arbitrate, forward AR, route R until RLAST.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int ARB_RR = 1,
    parameter int ID_W   = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [31:0]     i_araddr,
    input  logic [7:0]      i_arlen,
    input  logic [2:0]      i_arsize,
    input  logic            i_arvalid,
    output logic            i_arready,
    output logic [31:0]     i_rdata,
    output logic            i_rlast,
    output logic            i_rvalid,
    input  logic            i_rready,

    input  logic [31:0]     d_araddr,
    input  logic [7:0]      d_arlen,
    input  logic [2:0]      d_arsize,
    input  logic            d_arvalid,
    output logic            d_arready,
    output logic [31:0]     d_rdata,
    output logic            d_rlast,
    output logic            d_rvalid,
    input  logic            d_rready,

    output logic [31:0]     m_araddr,
    output logic [7:0]      m_arlen,
    output logic [2:0]      m_arsize,
    output logic [ID_W-1:0] m_arid,
    output logic            m_arvalid,
    input  logic            m_arready,
    input  logic [31:0]     m_rdata,
    input  logic [ID_W-1:0] m_rid,
    input  logic            m_rlast,
    input  logic            m_rvalid,
    output logic            m_rready
);

    localparam logic RR_MODE = (ARB_RR != 0);

    arb_state_t  state_r;
    arb_state_t  state_next_s;
    logic        gnt_r;
    logic        gnt_next_s;
    logic        last_g_r;
    logic        last_g_next_s;
    logic        pick_s;
    logic [1:0]  req_s;
    ar_payload_t sel_ar_s;
    logic        sel_arvalid_s;
    logic        sel_rready_s;
    logic        in_addr_s;
    logic        in_data_s;
    logic        ar_hs_s;
    logic        r_last_hs_s;
    logic        unused_rid_s;

    assign req_s = {d_arvalid, i_arvalid};

    rr_arb2 u_rr_arb2 (
        .req    (req_s),
        .last_g (last_g_r),
        .mode   (RR_MODE),
        .gnt    (pick_s)
    );

    // With a single burst in flight the grant register alone routes R, so m_rid is not needed.
    assign unused_rid_s = ^m_rid;

    // Granted side's AR payload and handshake inputs.
    always_comb begin
        if (gnt_r == GNT_D) begin
            sel_ar_s.addr = d_araddr;
            sel_ar_s.len  = d_arlen;
            sel_ar_s.size = d_arsize;
            sel_arvalid_s = d_arvalid;
            sel_rready_s  = d_rready;
        end else begin
            sel_ar_s.addr = i_araddr;
            sel_ar_s.len  = i_arlen;
            sel_ar_s.size = i_arsize;
            sel_arvalid_s = i_arvalid;
            sel_rready_s  = i_rready;
        end
    end

    // Reset silences every handshake in the same cycle it is sampled.
    assign in_addr_s   = (state_r == ARB_ADDR) && !rst;
    assign in_data_s   = (state_r == ARB_DATA) && !rst;
    assign ar_hs_s     = sel_arvalid_s && m_arready;
    assign r_last_hs_s = m_rvalid && sel_rready_s && m_rlast;

    // State, grant and round-robin history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ARB_IDLE;
            gnt_r    <= GNT_I;
            last_g_r <= GNT_D;
        end else begin
            state_r  <= state_next_s;
            gnt_r    <= gnt_next_s;
            last_g_r <= last_g_next_s;
        end
    end

    // Next-state, grant capture and history update.
    always_comb begin
        state_next_s  = state_r;
        gnt_next_s    = gnt_r;
        last_g_next_s = last_g_r;
        case (state_r)
            ARB_IDLE: begin
                if (req_s != 2'b00) begin
                    state_next_s  = ARB_ADDR;
                    gnt_next_s    = pick_s;
                    last_g_next_s = pick_s;
                end else begin
                    state_next_s  = ARB_IDLE;
                end
            end
            ARB_ADDR: begin
                if (ar_hs_s) begin
                    state_next_s = ARB_DATA;
                end else begin
                    state_next_s = ARB_ADDR;
                end
            end
            ARB_DATA: begin
                if (r_last_hs_s) begin
                    state_next_s = ARB_IDLE;
                end else begin
                    state_next_s = ARB_DATA;
                end
            end
            default: begin
                state_next_s = ARB_IDLE;
            end
        endcase
    end

    // AR/R handshake routing: only the granted side sees the bridge.
    always_comb begin
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        i_arready = 1'b0;
        d_arready = 1'b0;
        i_rvalid  = 1'b0;
        i_rlast   = 1'b0;
        d_rvalid  = 1'b0;
        d_rlast   = 1'b0;
        if (in_addr_s) begin
            m_arvalid = sel_arvalid_s;
            if (gnt_r == GNT_D) begin
                d_arready = m_arready;
            end else begin
                i_arready = m_arready;
            end
        end else if (in_data_s) begin
            m_rready = sel_rready_s;
            if (gnt_r == GNT_D) begin
                d_rvalid = m_rvalid;
                d_rlast  = m_rlast;
            end else begin
                i_rvalid = m_rvalid;
                i_rlast  = m_rlast;
            end
        end else begin
            m_arvalid = 1'b0;
        end
    end

    assign m_araddr = sel_ar_s.addr;
    assign m_arlen  = sel_ar_s.len;
    assign m_arsize = sel_ar_s.size;
    assign m_arid   = ID_W'(gnt_r);

    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: a round-robin instance driven by a
// bridge model, plus a fixed-priority instance used for the tie-order case.
module tb_axi_rd_arbiter;

    localparam int ID_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Round-robin instance signals
    logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata, m_araddr, m_rdata;
    logic [7:0]  i_arlen, d_arlen, m_arlen;
    logic [2:0]  i_arsize, d_arsize, m_arsize;
    logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
    logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
    logic [ID_W-1:0] m_arid, m_rid;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

    // Fixed-priority instance signals
    logic [31:0] f_i_araddr, f_d_araddr, f_i_rdata, f_d_rdata, f_m_araddr, f_m_rdata;
    logic [7:0]  f_i_arlen, f_d_arlen, f_m_arlen;
    logic [2:0]  f_i_arsize, f_d_arsize, f_m_arsize;
    logic        f_i_arvalid, f_i_arready, f_i_rlast, f_i_rvalid, f_i_rready;
    logic        f_d_arvalid, f_d_arready, f_d_rlast, f_d_rvalid, f_d_rready;
    logic [ID_W-1:0] f_m_arid, f_m_rid;
    logic        f_m_arvalid, f_m_arready, f_m_rlast, f_m_rvalid, f_m_rready;

    axi_rd_arbiter #(.ARB_RR(1), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
        .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
        .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
        .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
        .d_rready(d_rready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arid(m_arid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rid(m_rid),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    axi_rd_arbiter #(.ARB_RR(0), .ID_W(ID_W)) dut_fp (
        .clk(clk), .rst(rst),
        .i_araddr(f_i_araddr), .i_arlen(f_i_arlen), .i_arsize(f_i_arsize), .i_arvalid(f_i_arvalid),
        .i_arready(f_i_arready), .i_rdata(f_i_rdata), .i_rlast(f_i_rlast), .i_rvalid(f_i_rvalid),
        .i_rready(f_i_rready),
        .d_araddr(f_d_araddr), .d_arlen(f_d_arlen), .d_arsize(f_d_arsize), .d_arvalid(f_d_arvalid),
        .d_arready(f_d_arready), .d_rdata(f_d_rdata), .d_rlast(f_d_rlast), .d_rvalid(f_d_rvalid),
        .d_rready(f_d_rready),
        .m_araddr(f_m_araddr), .m_arlen(f_m_arlen), .m_arsize(f_m_arsize), .m_arid(f_m_arid),
        .m_arvalid(f_m_arvalid), .m_arready(f_m_arready), .m_rdata(f_m_rdata), .m_rid(f_m_rid),
        .m_rlast(f_m_rlast), .m_rvalid(f_m_rvalid), .m_rready(f_m_rready)
    );

    typedef struct packed {
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [ID_W-1:0] id;
    } ar_exp_t;

    typedef struct packed {
        logic        side;
        logic [31:0] data;
        logic        last;
    } r_exp_t;

    ar_exp_t         exp_ar[$];
    r_exp_t          exp_r[$];
    logic [31:0]     br_data[$];
    logic [ID_W-1:0] fp_exp[$];

    int n_checks = 0;
    int n_fail   = 0;

    int              beats_left;
    logic [ID_W-1:0] br_id;
    logic            ar_hs_f, r_hs_f, i_ar_hs_f, d_ar_hs_f, f_i_hs_f, f_d_hs_f;
    logic [7:0]      ar_len_f;
    logic [ID_W-1:0] ar_id_f;
    logic            toggle_rr;
    logic            rlast_seen;
    int              beat_cnt;
    logic [31:0]     tmp_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_beat(input logic side, input logic [31:0] data, input logic last);
        r_exp_t r;
        check_eq("r_expected", exp_r.size() != 0, 1'b1);
        if (exp_r.size() != 0) begin
            r = exp_r.pop_front();
            check_eq("r_side", side, r.side);
            check_eq("r_data", data, r.data);
            check_eq("r_last", last, r.last);
            if (last) rlast_seen = 1'b1;
            beat_cnt++;
        end
    endtask

    // Sampled mid-cycle: compares DUT output events with the scoreboard.
    task automatic monitor();
        ar_exp_t a;
        ar_hs_f   = m_arvalid && m_arready;
        ar_len_f  = m_arlen;
        ar_id_f   = m_arid;
        r_hs_f    = m_rvalid && m_rready;
        i_ar_hs_f = i_arvalid && i_arready;
        d_ar_hs_f = d_arvalid && d_arready;
        f_i_hs_f  = f_i_arvalid && f_i_arready;
        f_d_hs_f  = f_d_arvalid && f_d_arready;
        if (ar_hs_f) begin
            check_eq("ar_expected", exp_ar.size() != 0, 1'b1);
            if (exp_ar.size() != 0) begin
                a = exp_ar.pop_front();
                check_eq("ar_addr", m_araddr, a.addr);
                check_eq("ar_len", m_arlen, a.len);
                check_eq("ar_size", m_arsize, a.size);
                check_eq("ar_id", m_arid, a.id);
            end
        end
        if (i_rvalid) check_eq("i_phase", {d_rvalid, m_rready}, {1'b0, i_rready});
        if (d_rvalid) check_eq("d_phase", {i_rvalid, m_rready}, {1'b0, d_rready});
        if (i_rvalid && i_rready) check_beat(1'b0, i_rdata, i_rlast);
        if (d_rvalid && d_rready) check_beat(1'b1, d_rdata, d_rlast);
        if (f_m_arvalid && f_m_arready) begin
            check_eq("fp_expected", fp_exp.size() != 0, 1'b1);
            if (fp_exp.size() != 0) check_eq("fp_grant", f_m_arid, fp_exp.pop_front());
        end
    endtask

    // Just after the clock edge: master drops and bridge R-channel model.
    task automatic drive_models();
        if (i_ar_hs_f) i_arvalid = 1'b0;
        if (d_ar_hs_f) d_arvalid = 1'b0;
        if (f_i_hs_f)  f_i_arvalid = 1'b0;
        if (f_d_hs_f)  f_d_arvalid = 1'b0;
        if (rst) begin
            beats_left = 0;
            br_data.delete();
        end else begin
            if (ar_hs_f) begin
                beats_left = int'(ar_len_f) + 1;
                br_id      = ar_id_f;
            end
            if (r_hs_f) begin
                beats_left--;
                if (br_data.size() != 0) tmp_data = br_data.pop_front();
            end
        end
        m_rvalid = (beats_left > 0);
        m_rlast  = (beats_left == 1);
        m_rdata  = (br_data.size() != 0) ? br_data[0] : 32'h0;
        m_rid    = br_id;
        if (toggle_rr) i_rready = ~i_rready;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive_models();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((exp_ar.size() + exp_r.size() + fp_exp.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, exp_ar.size() + exp_r.size() + fp_exp.size(), 0);
    endtask

    task automatic post_req(input logic side, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] base);
        ar_exp_t a;
        r_exp_t  r;
        if (side) begin
            d_araddr = addr; d_arlen = len; d_arsize = 3'd2; d_arvalid = 1'b1;
        end else begin
            i_araddr = addr; i_arlen = len; i_arsize = 3'd2; i_arvalid = 1'b1;
        end
        a.addr = addr; a.len = len; a.size = 3'd2; a.id = ID_W'(side);
        exp_ar.push_back(a);
        for (int k = 0; k <= int'(len); k++) begin
            r.side = side;
            r.data = base + 32'(k);
            r.last = (k == int'(len));
            exp_r.push_back(r);
            br_data.push_back(base + 32'(k));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        i_araddr = 32'h0; i_arlen = 8'h0; i_arsize = 3'h0; i_arvalid = 1'b0; i_rready = 1'b1;
        d_araddr = 32'h0; d_arlen = 8'h0; d_arsize = 3'h0; d_arvalid = 1'b0; d_rready = 1'b1;
        m_arready = 1'b1; m_rdata = 32'h0; m_rid = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        f_i_araddr = 32'h0; f_i_arlen = 8'h0; f_i_arsize = 3'h0; f_i_arvalid = 1'b0; f_i_rready = 1'b1;
        f_d_araddr = 32'h0; f_d_arlen = 8'h0; f_d_arsize = 3'h0; f_d_arvalid = 1'b0; f_d_rready = 1'b1;
        f_m_arready = 1'b1; f_m_rdata = 32'h0; f_m_rid = '0; f_m_rlast = 1'b1; f_m_rvalid = 1'b1;
        beats_left = 0; br_id = '0; toggle_rr = 1'b0; rlast_seen = 1'b0; beat_cnt = 0;
        tmp_data = 32'h0;
        ar_hs_f = 1'b0; r_hs_f = 1'b0; i_ar_hs_f = 1'b0; d_ar_hs_f = 1'b0;
        f_i_hs_f = 1'b0; f_d_hs_f = 1'b0; ar_len_f = 8'h0; ar_id_f = '0;

        repeat (3) step();
        settle();
        check_eq("reset_outputs",
                 {m_arvalid, m_rready, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast, f_m_arvalid},
                 9'h000);
        rst = 1'b0;
        step();

        // Simultaneous requests: RR grants I then D (history starts at D); fixed priority D then I.
        post_req(1'b0, 32'h1000_0000, 8'd1, 32'h0000_1100);
        post_req(1'b1, 32'h2000_0000, 8'd1, 32'h0000_2200);
        f_i_arvalid = 1'b1; f_d_arvalid = 1'b1;
        fp_exp.push_back(ID_W'(1)); fp_exp.push_back(ID_W'(0));
        wait_done("tie_first", 80);
        post_req(1'b0, 32'h1000_0100, 8'd1, 32'h0000_1300);
        post_req(1'b1, 32'h2000_0100, 8'd1, 32'h0000_2400);
        wait_done("tie_second", 80);

        // I-only burst of 8 with one-cycle arbitration bubble.
        post_req(1'b0, 32'h1FC0_0040, 8'd7, 32'h0000_00A0);
        settle();
        check_eq("ar_bubble", m_arvalid, 1'b0);
        step();
        settle();
        check_eq("ar_first", {m_arvalid, m_arid, m_araddr}, {1'b1, 4'd0, 32'h1FC0_0040});
        wait_done("i_only", 40);
        settle();
        check_eq("i_only_idle", {m_arvalid, m_rready, i_rvalid, d_rvalid}, 4'b0000);

        // AR back-pressure, then R back-pressure by toggling i_rready.
        m_arready = 1'b0;
        post_req(1'b0, 32'h3000_0040, 8'd3, 32'h0000_00B0);
        step();
        for (int k = 0; k < 5; k++) begin
            settle();
            check_eq("bp_hold", {m_arvalid, m_araddr, m_arlen, i_arready},
                     {1'b1, 32'h3000_0040, 8'd3, 1'b0});
            step();
        end
        m_arready = 1'b1;
        settle();
        check_eq("bp_accept", i_arready, 1'b1);
        toggle_rr = 1'b1;
        wait_done("bp", 60);
        toggle_rr = 1'b0;
        i_rready = 1'b1;

        // Uncached single-beat D read.
        post_req(1'b1, 32'h4000_0000, 8'd0, 32'hDEAD_BEEF);
        wait_done("uncached", 20);
        settle();
        check_eq("uncached_idle", {m_arvalid, m_rready, d_rvalid}, 3'b000);

        // D request arrives while an I burst is in flight.
        rlast_seen = 1'b0;
        post_req(1'b0, 32'h5000_0000, 8'd7, 32'h0000_0050);
        repeat (3) step();
        post_req(1'b1, 32'h6000_0000, 8'd0, 32'h0000_00C0);
        n = 0;
        while (!rlast_seen && n < 40) begin
            settle();
            check_eq("pend_d_arready", d_arready, 1'b0);
            step();
            n++;
        end
        settle();
        check_eq("pend_bubble", m_arvalid, 1'b0);
        step();
        settle();
        check_eq("pend_grant_d", {m_arvalid, m_arid}, {1'b1, 4'd1});
        wait_done("pend", 20);

        // Reset on beat 3 of 8, then a fresh I request.
        beat_cnt = 0;
        post_req(1'b0, 32'h7000_0000, 8'd7, 32'h0000_0070);
        n = 0;
        while (beat_cnt < 2 && n < 30) begin
            step();
            n++;
        end
        check_eq("rst_reach_beat3", beat_cnt, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_r.delete();
        exp_ar.delete();
        settle();
        check_eq("rst_mid",
                 {m_rready, m_arvalid, i_rvalid, d_rvalid, i_arready, d_arready, i_rlast, d_rlast},
                 8'h00);
        post_req(1'b0, 32'h7100_0000, 8'd1, 32'h0000_00E0);
        wait_done("post_rst", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
